// File: rtl/uds_ctrl.sv
// Row sequencer for the UDS datapath: buffers two upstream rows per pair, issues them
// back-to-back with a one-cycle gap, and counts UDS results until the job is complete.
module uds_ctrl #(
    parameter int A  = 64,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      cfg_scale,
    input  logic [1:0]      cfg_mode,
    input  logic [CW-1:0]   cfg_pairs,
    input  logic [A*32-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [A*32-1:0] uds_idata,
    output logic            uds_idata_valid,
    output logic            uds_active,
    output logic [1:0]      uds_scale_factor,
    output logic [1:0]      uds_function_mode,
    input  logic            uds_odata_valid,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   out_count,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_ISSUE_B, S_GAP, S_DRAIN, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        scale_q, scale_d, mode_q, mode_d;
    logic [CW-1:0]     pairs_q, pairs_d, pair_cnt_q, pair_cnt_d, out_cnt_q, out_cnt_d;
    logic [A*32-1:0]   buf_a_q, buf_a_d, buf_b_q, buf_b_d, idata_q, idata_d;
    logic              ivalid_q, ivalid_d, active_q, active_d, done_q, done_d;

    // Upstream handshake: a row moves on a rising edge where in_valid and in_ready are
    // both 1; in_ready depends on state only, so the source may hold in_valid freely.
    assign in_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        scale_d    = scale_q;
        mode_d     = mode_q;
        pairs_d    = pairs_q;
        pair_cnt_d = pair_cnt_q;
        out_cnt_d  = out_cnt_q;
        buf_a_d    = buf_a_q;
        buf_b_d    = buf_b_q;
        idata_d    = idata_q;
        ivalid_d   = 1'b0;
        active_d   = 1'b0;
        done_d     = (state_q == S_DONE);

        if (busy && uds_odata_valid && (out_cnt_q != {CW{1'b1}})) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    scale_d    = cfg_scale;
                    mode_d     = cfg_mode;
                    pairs_d    = cfg_pairs;
                    pair_cnt_d = '0;
                    out_cnt_d  = '0;
                    state_d    = (cfg_pairs != '0) ? S_LOAD_A : S_DONE;
                end
            end
            S_LOAD_A: begin
                if (in_valid) begin
                    buf_a_d = in_data;
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                // Both rows are buffered before issue, so stalls never split a pair.
                if (in_valid) begin
                    buf_b_d  = in_data;
                    idata_d  = buf_a_q;
                    ivalid_d = 1'b1;
                    state_d  = S_ISSUE_B;
                end
            end
            S_ISSUE_B: begin
                idata_d  = buf_b_q;
                ivalid_d = 1'b1;
                active_d = 1'b1;
                state_d  = S_GAP;
            end
            S_GAP: begin
                pair_cnt_d = pair_cnt_q + 1'b1;
                state_d    = (pair_cnt_d == pairs_q) ? S_DRAIN : S_LOAD_A;
            end
            S_DRAIN: begin
                // Look at the next count so a result arriving now ends the drain next cycle.
                if (out_cnt_d == pairs_q) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            scale_q    <= '0;
            mode_q     <= '0;
            pairs_q    <= '0;
            pair_cnt_q <= '0;
            out_cnt_q  <= '0;
            buf_a_q    <= '0;
            buf_b_q    <= '0;
            idata_q    <= '0;
            ivalid_q   <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scale_q    <= scale_d;
            mode_q     <= mode_d;
            pairs_q    <= pairs_d;
            pair_cnt_q <= pair_cnt_d;
            out_cnt_q  <= out_cnt_d;
            buf_a_q    <= buf_a_d;
            buf_b_q    <= buf_b_d;
            idata_q    <= idata_d;
            ivalid_q   <= ivalid_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    assign uds_idata         = idata_q;
    assign uds_idata_valid   = ivalid_q;
    assign uds_active        = active_q;
    assign uds_scale_factor  = scale_q;
    assign uds_function_mode = mode_q;
    assign done              = done_q;
    assign out_count         = out_cnt_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_uds_ctrl.sv
// Bench for uds_ctrl: random rows and stalls, expected UDS beat queue, and a responder
// that returns one result per issued pair after a programmable delay.
module tb_uds_ctrl;
    localparam int A  = 4;
    localparam int CW = 8;
    localparam int W  = A * 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    cfg_scale = '0;
    logic [1:0]    cfg_mode = '0;
    logic [CW-1:0] cfg_pairs = '0;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  uds_idata;
    logic          uds_idata_valid, uds_active;
    logic [1:0]    uds_scale_factor, uds_function_mode;
    logic          uds_odata_valid = 1'b0;
    logic          busy, done;
    logic [CW-1:0] out_count;
    logic [2:0]    dbg_state;

    uds_ctrl #(.A(A), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_scale(cfg_scale), .cfg_mode(cfg_mode), .cfg_pairs(cfg_pairs),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .uds_idata(uds_idata), .uds_idata_valid(uds_idata_valid), .uds_active(uds_active),
        .uds_scale_factor(uds_scale_factor), .uds_function_mode(uds_function_mode),
        .uds_odata_valid(uds_odata_valid),
        .busy(busy), .done(done), .out_count(out_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    logic [W-1:0] exp_q[$];
    bit           act_q[$];
    int           due_q[$];
    int           resp_delay = 4;
    logic [1:0]   exp_scale = '0;
    logic [1:0]   exp_mode = '0;
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           last_act_cyc = 0;
    bit           prev_valid = 1'b0;
    bit           prev_active = 1'b0;
    logic [W-1:0] exp_row;
    bit           exp_act;

    always @(posedge clk) cyc <= cyc + 1;

    // Observes the UDS side every cycle and plays the UDS responder.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_active = 1'b0;
            uds_odata_valid = 1'b0;
        end else begin
            n_cmp++;
            if (uds_active && !uds_idata_valid) begin
                n_err++;
                $display("FAIL active_without_valid cyc=%0d got active=1 valid=0 want active=0", cyc);
            end
            if (uds_idata_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_row cyc=%0d got row %h want no row", cyc, uds_idata);
                end else begin
                    exp_row = exp_q.pop_front();
                    exp_act = act_q.pop_front();
                    if (uds_idata !== exp_row || uds_active !== exp_act) begin
                        n_err++;
                        $display("FAIL row_data cyc=%0d got %h/%0b want %h/%0b",
                                 cyc, uds_idata, uds_active, exp_row, exp_act);
                    end
                    if (exp_act) begin
                        n_cmp++;
                        if (!(prev_valid && !prev_active)) begin
                            n_err++;
                            $display("FAIL pair_adjacent cyc=%0d got prev_valid=%0b prev_active=%0b want 1/0",
                                     cyc, prev_valid, prev_active);
                        end
                    end
                end
            end
            if (prev_active) begin
                n_cmp++;
                if (uds_idata_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL gap_after_pair cyc=%0d got valid=%0b want 0", cyc, uds_idata_valid);
                end
            end
            if (busy) begin
                n_cmp++;
                if (uds_scale_factor !== exp_scale || uds_function_mode !== exp_mode) begin
                    n_err++;
                    $display("FAIL cfg_stable cyc=%0d got %0d/%0d want %0d/%0d",
                             cyc, uds_scale_factor, uds_function_mode, exp_scale, exp_mode);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (uds_idata_valid && uds_active) begin
                last_act_cyc = cyc;
                due_q.push_back(cyc + resp_delay);
            end
            uds_odata_valid = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                uds_odata_valid = 1'b1;
            end
            prev_valid = uds_idata_valid;
            prev_active = uds_active;
        end
    end

    task automatic start_job(input int pairs, input int sc, input int md);
        cfg_pairs = CW'(pairs);
        cfg_scale = sc[1:0];
        cfg_mode  = md[1:0];
        exp_scale = sc[1:0];
        exp_mode  = md[1:0];
        done_cnt  = 0;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic feed_rows(input int n, input int stall_max, input int force_idx, input int force_stall);
        for (int i = 0; i < n; i++) begin
            int stalls;
            int guard;
            bit ok;
            logic [W-1:0] row;
            stalls = (i == force_idx) ? force_stall : $urandom_range(stall_max, 0);
            in_valid = 1'b0;
            repeat (stalls) @(negedge clk);
            for (int k = 0; k < A; k++) row[k*32 +: 32] = $urandom;
            in_data = row;
            in_valid = 1'b1;
            ok = 1'b0;
            guard = 0;
            while (!ok && guard < 100) begin
                ok = in_ready;
                @(negedge clk);
                guard++;
            end
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL in_ready_timeout row=%0d got no transfer want transfer", i);
            end else begin
                exp_q.push_back(row);
                act_q.push_back(i % 2 == 1);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int pairs);
        int guard;
        guard = 0;
        while (done !== 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL done_timeout got done=%b want 1", done);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL done_once got %0d pulses want 1", done_cnt);
        end
        n_cmp++;
        if (busy !== 1'b0 || out_count !== CW'(pairs)) begin
            n_err++;
            $display("FAIL job_end got busy=%b out_count=%0d want 0/%0d", busy, out_count, pairs);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rows_left got %0d want 0", exp_q.size());
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_cmp++;
        if (uds_idata !== '0 || uds_idata_valid !== 1'b0 || uds_active !== 1'b0 ||
            uds_scale_factor !== 2'd0 || uds_function_mode !== 2'd0 || done !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b0 || out_count !== '0) begin
            n_err++;
            $display("FAIL %s got v=%b a=%b sc=%0d md=%0d done=%b busy=%b rdy=%b cnt=%0d data=%h want all 0",
                     tag, uds_idata_valid, uds_active, uds_scale_factor, uds_function_mode,
                     done, busy, in_ready, out_count, uds_idata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_values");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_basic();
        resp_delay = 4;
        start_job(3, 0, 0);
        feed_rows(6, 0, -1, 0);
        wait_done(3);
        n_cmp++;
        if (done_cyc - last_act_cyc != resp_delay + 2) begin
            n_err++;
            $display("FAIL basic_done_timing got %0d want %0d", done_cyc - last_act_cyc, resp_delay + 2);
        end
    endtask

    task automatic test_stall();
        resp_delay = 4;
        start_job(3, 1, 2);
        feed_rows(6, 2, 1, 3);
        wait_done(3);
    endtask

    task automatic test_zero_pairs();
        start_job(0, 2, 3);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL zero_pairs_c1 got done=%b busy=%b want 0/1", done, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_pairs_c2 got done=%b busy=%b want 1/0", done, busy);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL zero_pairs_once got %0d pulses want 1", done_cnt);
        end
    endtask

    task automatic test_restart_ignored();
        resp_delay = 4;
        start_job(2, 0, 1);
        fork
            feed_rows(4, 1, -1, 0);
            begin
                repeat (5) @(negedge clk);
                cfg_scale = 2'd2;
                cfg_pairs = CW'(1);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        wait_done(2);
        n_cmp++;
        if (uds_scale_factor !== 2'd0) begin
            n_err++;
            $display("FAIL restart_scale got %0d want 0", uds_scale_factor);
        end
    endtask

    task automatic test_async_reset();
        resp_delay = 4;
        start_job(3, 3, 3);
        feed_rows(3, 0, -1, 0);
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        act_q.delete();
        due_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || uds_idata_valid !== 1'b0) begin
            n_err++;
            $display("FAIL no_reissue got busy=%b valid=%b want 0/0", busy, uds_idata_valid);
        end
        start_job(1, 1, 1);
        feed_rows(2, 1, -1, 0);
        wait_done(1);
    endtask

    task automatic test_gap_odata();
        resp_delay = 0;
        start_job(2, 2, 1);
        feed_rows(4, 0, -1, 0);
        wait_done(2);
        n_cmp++;
        if (done_cyc - last_act_cyc != 3) begin
            n_err++;
            $display("FAIL gap_odata_timing got %0d want 3", done_cyc - last_act_cyc);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            int pairs;
            int lat;
            pairs = $urandom_range(5, 1);
            resp_delay = $urandom_range(6, 0);
            lat = ((resp_delay == 0) ? 1 : resp_delay) + 2;
            start_job(pairs, $urandom_range(3, 0), $urandom_range(3, 0));
            feed_rows(2 * pairs, $urandom_range(3, 0), -1, 0);
            wait_done(pairs);
            n_cmp++;
            if (done_cyc - last_act_cyc != lat) begin
                n_err++;
                $display("FAIL random_done_timing job=%0d got %0d want %0d", j, done_cyc - last_act_cyc, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_pairs();
        test_restart_ignored();
        test_async_reset();
        test_gap_odata();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uds_ctrl.md
UDS_CTRL -- requirements
Module: uds_ctrl

Interface
REQ-001 Parameter A, default 64, 32-bit words per input row; the row bus is A*32 bits wide.
REQ-002 Parameter CW, default 8, width of the pair and output counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to run one job; honoured only in IDLE.
REQ-006 cfg_scale  input  2  scale factor for the job; latched on an accepted start.
REQ-007 cfg_mode  input  2  function mode for the job; latched on an accepted start.
REQ-008 cfg_pairs  input  CW  number of row pairs in the job; latched on an accepted start.
REQ-009 in_data, in_valid / in_ready  input A*32, input 1 / output 1  upstream row stream with valid/ready handshake.
REQ-010 uds_idata, uds_idata_valid, uds_active  output A*32, 1, 1  row bus, row valid and second-row marker to the UDS datapath.
REQ-011 uds_scale_factor, uds_function_mode  output 2, 2  latched job configuration to UDS.
REQ-012 uds_odata_valid  input  1  UDS result-valid pulse; one pulse per row pair.
REQ-013 busy, done, out_count  output 1, 1, CW  job active; one-cycle completion pulse; results received in the current job.

Function
REQ-014 States SHALL be IDLE, LOAD_A, LOAD_B, ISSUE_B, GAP, DRAIN and DONE.
REQ-015 IDLE, start=1 and cfg_pairs>0: latch the configuration, clear the pair and output counters, go to LOAD_A.
REQ-016 IDLE, start=1 and cfg_pairs=0: latch the configuration, go directly to DONE.
REQ-017 in_ready=1 only in LOAD_A and LOAD_B; a transfer occurs only when in_valid and in_ready are both 1.
REQ-018 LOAD_A, on transfer: store the row in buffer A, go to LOAD_B; uds_idata_valid stays 0.
REQ-019 LOAD_B, on transfer: the next cycle drives uds_idata = buffer A, uds_idata_valid=1, uds_active=0; store the row in buffer B; go to ISSUE_B.
REQ-020 ISSUE_B: the next cycle drives uds_idata = buffer B, uds_idata_valid=1, uds_active=1; go to GAP.
REQ-021 GAP: hold for exactly one cycle with uds_idata_valid=0 and uds_active=0, and increment the pair counter.
REQ-022 GAP exit: go to DRAIN if the incremented pair count equals cfg_pairs, otherwise go to LOAD_A.
REQ-023 The two rows of a pair SHALL appear on consecutive cycles with no bubble, whatever upstream stalls occur.
REQ-024 Upstream stalls are allowed only in LOAD_A or LOAD_B; in those states uds_idata_valid=0.
REQ-025 uds_active SHALL be 1 only together with uds_idata_valid=1 and only for the second row of a pair.
REQ-026 out_count increments on each uds_odata_valid while busy, saturating at all-ones; pulses outside busy are ignored.
REQ-027 DRAIN: go to DONE when out_count equals cfg_pairs.
REQ-028 DRAIN, uds_odata_valid arriving in the same cycle that makes out_count equal cfg_pairs: DONE is entered on the next cycle.
REQ-029 DONE lasts one cycle with done=1, then returns to IDLE; out_count holds its value until the next accepted start.
REQ-030 busy=1 in every state except IDLE; start while busy is ignored and changes no configuration.
REQ-031 uds_scale_factor and uds_function_mode SHALL remain stable from the accepted start until the next accepted start.
REQ-032 All outputs except in_ready and busy SHALL be registered; in_ready and busy are decoded from state only.

Reset
REQ-033 rst=1 forces IDLE immediately, at any point including mid-pair or during DRAIN.
REQ-034 Reset values: uds_idata=0, uds_idata_valid=0, uds_active=0, uds_scale_factor=0, uds_function_mode=0.
REQ-035 Reset values: done=0, busy=0, in_ready=0, out_count=0; internal counters and buffers = 0.
REQ-036 After rst falls, the block waits for a new start; no partial pair is reissued.

Verification
REQ-037 start with cfg_pairs=3, scale=0, mode=0, rows R0..R5 back-to-back, one odata_valid 4 cycles after each second row -> UDS sees (R0,a0),(R1,a1),idle,(R2,a0),(R3,a1),idle,(R4,a0),(R5,a1),idle; done pulses once; out_count=3.
REQ-038 Same job with in_valid dropped 3 cycles between R0 and R1 -> R0 and R1 still appear on adjacent cycles; no uds_active without uds_idata_valid.
REQ-039 start with cfg_pairs=0 -> done=1 exactly 2 cycles after start; uds_idata_valid never asserts.
REQ-040 start pulsed again mid-job with scale=2 -> ignored; uds_scale_factor stays 0 until done.
REQ-041 rst asserted the cycle after R2 is accepted -> all outputs 0 asynchronously; a fresh job with cfg_pairs=1 then completes normally.
REQ-042 Last odata_valid arriving in the GAP cycle of the final pair -> DRAIN exits after 1 cycle; done pulses once.
